// File: rtl/adh_unit_if.sv
// Bus bundle for the address-high unit: source select, operand bytes, fix-up control and registered outputs.
interface adh_unit_if #(
    parameter int DW = 8
);
    logic [3:0]    sel;
    logic [DW-1:0] pch;
    logic [DW-1:0] dreg;
    logic [DW-1:0] alu;
    logic          carry;
    logic          fix_en;
    logic          hold;
    logic [DW-1:0] y;
    logic          stall;
    logic          wrap;

    modport master (
        output sel, pch, dreg, alu, carry, fix_en, hold,
        input  y, stall, wrap
    );

    modport slave (
        input  sel, pch, dreg, alu, carry, fix_en, hold,
        output y, stall, wrap
    );
endinterface

// File: rtl/adh_unit.sv
// Address-high register with source mux and optional page-cross fix-up (enabled by macro ADH_FIXUP_EN).
// Without ADH_FIXUP_EN the block is a plain registered mux with hold; stall and wrap stay 0.
module adh_unit #(
    parameter int            DW         = 8,
    parameter logic [DW-1:0] STACK_PAGE = DW'(1),
    parameter logic [DW-1:0] ZERO_PAGE  = DW'(0)
) (
    input  logic       clk,
    input  logic       reset,
    adh_unit_if.slave  bus
);

    localparam logic [0:0] NORM = 1'b0;
    localparam logic [0:0] FIX  = 1'b1;

    // Page selects win over everything; otherwise an AND-OR merge of alu and dreg.
    function automatic logic [DW-1:0] src_mux(
        input logic [3:0]    sel,
        input logic [DW-1:0] pch,
        input logic [DW-1:0] dreg,
        input logic [DW-1:0] alu
    );
        logic [DW-1:0] r;
        if (sel[1])
            r = ZERO_PAGE;
        else if (sel[0])
            r = STACK_PAGE;
        else if (sel == 4'b0000)
            r = pch;
        else
            r = (alu & {DW{sel[3]}}) | (dreg & {DW{sel[2]}});
        return r;
    endfunction

    logic [DW-1:0] y_q, y_d;
    logic [DW-1:0] mux_out;

    assign mux_out = src_mux(bus.sel, bus.pch, bus.dreg, bus.alu);

`ifdef ADH_FIXUP_EN
    localparam logic [DW-1:0] ONE = DW'(1);

    logic [0:0] state_q, state_d;
    logic       wrap_q, wrap_d;

    always_comb begin
        y_d     = y_q;
        state_d = state_q;
        wrap_d  = wrap_q;
        if (!bus.hold) begin
            if (state_q == FIX) begin
                // Fix-up cycle: bump the page, ignore the sequencer inputs.
                y_d     = y_q + ONE;
                wrap_d  = &y_q;
                state_d = NORM;
            end else begin
                y_d     = mux_out;
                wrap_d  = 1'b0;
                state_d = (bus.carry && bus.fix_en) ? FIX : NORM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q     <= '0;
            state_q <= NORM;
            wrap_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.stall = (state_q == FIX);
    assign bus.wrap  = wrap_q;
`else
    logic unused_fixup_inputs;
    assign unused_fixup_inputs = bus.carry ^ bus.fix_en ^ NORM[0] ^ FIX[0];

    always_comb begin
        y_d = bus.hold ? y_q : mux_out;
    end

    always_ff @(posedge clk) begin
        if (reset)
            y_q <= '0;
        else
            y_q <= y_d;
    end

    assign bus.stall = 1'b0;
    assign bus.wrap  = 1'b0;
`endif

    assign bus.y = y_q;

endmodule

// File: tb/tb_adh_unit.sv
// Self-checking bench for adh_unit: directed scenarios plus randomized traffic against a cycle model.
module tb_adh_unit;

`ifdef ADH_FIXUP_EN
    localparam bit FIXUP = 1'b1;
`else
    localparam bit FIXUP = 1'b0;
`endif

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    adh_unit_if #(.DW(DW)) bus();

    adh_unit #(.DW(DW), .STACK_PAGE(8'h01), .ZERO_PAGE(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: what the address-high byte, fix-up pending flag and wrap flag should be.
    logic [DW-1:0] m_y;
    bit            m_fix;
    bit            m_wrap;

    function automatic logic [DW-1:0] ref_src(input logic [3:0] s, input logic [DW-1:0] p,
                                              input logic [DW-1:0] d, input logic [DW-1:0] a);
        logic [DW-1:0] r;
        r = '0;
        if (s[1])            r = 8'h00;
        else if (s[0])       r = 8'h01;
        else if (s == 4'd0)  r = p;
        else begin
            if (s[3]) r = r | a;
            if (s[2]) r = r | d;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_edge();
        if (reset) begin
            m_y = '0; m_fix = 0; m_wrap = 0;
        end else if (!bus.hold) begin
            if (m_fix) begin
                m_wrap = (m_y == 8'hFF);
                m_y    = (m_y + 1) % 256;
                m_fix  = 0;
            end else begin
                m_y    = ref_src(bus.sel, bus.pch, bus.dreg, bus.alu);
                m_wrap = 0;
                m_fix  = FIXUP && bus.carry && bus.fix_en;
            end
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [7:0] p, input logic [7:0] d,
                        input logic [7:0] a, input logic c, input logic fe,
                        input logic h, input logic r);
        bus.sel = s; bus.pch = p; bus.dreg = d; bus.alu = a;
        bus.carry = c; bus.fix_en = fe; bus.hold = h; reset = r;
        @(posedge clk);
        model_edge();
        #1;
        chk("model_y", bus.y, m_y);
        chk("model_stall", bus.stall, m_fix);
        chk("model_wrap", bus.wrap, m_wrap);
    endtask

    initial begin
        bus.sel = 0; bus.pch = 0; bus.dreg = 0; bus.alu = 0;
        bus.carry = 0; bus.fix_en = 0; bus.hold = 0; reset = 1;
        m_y = 0; m_fix = 0; m_wrap = 0;
        @(negedge clk);

        step(4'b0000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        chk("reset_y", bus.y, 8'h00);
        chk("reset_stall", bus.stall, 1'b0);
        chk("reset_wrap", bus.wrap, 1'b0);

        step(4'b0000, 8'h12, 8'hA5, 8'h3C, 0, 0, 0, 0);
        chk("pch_y", bus.y, 8'h12);
        chk("pch_stall", bus.stall, 1'b0);

        step(4'b0001, 8'h12, 8'hA5, 8'h3C, 0, 0, 0, 0); chk("stack_y", bus.y, 8'h01);
        step(4'b0010, 8'h12, 8'hA5, 8'h3C, 0, 0, 0, 0); chk("zero_y", bus.y, 8'h00);
        step(4'b0100, 8'h12, 8'hA5, 8'h3C, 0, 0, 0, 0); chk("dreg_y", bus.y, 8'hA5);
        step(4'b1000, 8'h12, 8'hA5, 8'h3C, 0, 0, 0, 0); chk("alu_y", bus.y, 8'h3C);
        step(4'b0011, 8'h12, 8'hA5, 8'h3C, 0, 0, 0, 0); chk("prio_y", bus.y, 8'h00);
        step(4'b1100, 8'h12, 8'hA5, 8'h3C, 0, 0, 0, 0); chk("or_y", bus.y, 8'hBD);

        // Page-cross fix-up on alu=20.
        step(4'b1000, 8'h00, 8'h00, 8'h20, 1, 1, 0, 0);
        chk("fix_load_y", bus.y, 8'h20);
        chk("fix_stall", bus.stall, FIXUP);
        step(4'b1000, 8'h00, 8'h00, 8'h20, 0, 0, 0, 0);
        chk("fix_inc_y", bus.y, FIXUP ? 8'h21 : 8'h20);
        chk("fix_done_stall", bus.stall, 1'b0);

        // Wrap from FF.
        step(4'b1000, 8'h00, 8'h00, 8'hFF, 1, 1, 0, 0);
        chk("wrap_load_y", bus.y, 8'hFF);
        step(4'b1000, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 0);
        chk("wrap_y", bus.y, FIXUP ? 8'h00 : 8'hFF);
        chk("wrap_pulse", bus.wrap, FIXUP);
        step(4'b1000, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 0);
        chk("wrap_clear", bus.wrap, 1'b0);

        // Hold during FIX, then release.
        step(4'b1000, 8'h00, 8'h00, 8'h20, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 8'h00, 8'h77, 8'h55, 1, 1, 1, 0);
            chk("hold_y", bus.y, 8'h20);
            chk("hold_stall", bus.stall, FIXUP);
        end
        step(4'b0100, 8'h00, 8'h77, 8'h55, 1, 1, 0, 0);
        chk("release_y", bus.y, FIXUP ? 8'h21 : 8'h77);

        // Reset aborts a pending fix-up.
        step(4'b1000, 8'h00, 8'h00, 8'h20, 1, 1, 0, 0);
        step(4'b1000, 8'h00, 8'h00, 8'h20, 0, 0, 1, 1);
        chk("abort_y", bus.y, 8'h00);
        chk("abort_stall", bus.stall, 1'b0);

        // Carry without fix_en is ignored.
        step(4'b1000, 8'h00, 8'h00, 8'h40, 1, 0, 0, 0);
        chk("nofix_stall", bus.stall, 1'b0);

        // Back-to-back fix-ups.
        step(4'b1000, 8'h00, 8'h00, 8'h30, 1, 1, 0, 0);
        step(4'b1000, 8'h00, 8'h00, 8'h50, 1, 1, 0, 0);
        chk("b2b_inc_y", bus.y, FIXUP ? 8'h31 : 8'h50);
        step(4'b1000, 8'h00, 8'h00, 8'h50, 1, 1, 0, 0);
        chk("b2b_reenter", bus.stall, FIXUP);

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
